fifo_rd_arbiter: RTL and testbench

Round-robin read-side arbiter that shares one asynchronous FIFO read port among NUM_REQ consumers in the read clock domain. It drives the FIFO's read-increment, watches its empty flag, and steers the combinational read data to the single granted consumer. Grants last for a bounded burst, then rotate. The block sits between the FIFO read-pointer/memory logic and the downstream consumers.

---
 rtl/fifo_rd_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one async-FIFO read port among NUM_REQ consumers.
// Define FIFO_ARB_BURST_EN for up to MAX_BURST pops per grant; otherwise one pop per grant.
module fifo_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rdy,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rvalid,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      g_reg, g_next;
  logic [IW-1:0]      last_reg, last_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [IW-1:0]      pick, cand;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_valid;
  logic               xfer;
  logic               burst_done;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  assign burst_done = (cnt_reg == CW'(MAX_BURST - 1));
`else
  logic unused_max_burst;
  assign unused_max_burst = ^MAX_BURST;
  assign burst_done       = 1'b1;
`endif

  // Descending scan so the closest requester after last_reg is the one that sticks.
  always_comb begin
    pick       = last_reg;
    pick_valid = 1'b0;
    cand       = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IW'((int'(last_reg) + off) % NUM_REQ);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign pick_onehot[gi] = (pick == IW'(gi));
      assign rvalid[gi]      = gnt_reg[gi] & ~rempty;
    end
  endgenerate

  // Reset gates the pop combinationally so a mid-burst reset never loses a word.
  assign xfer = (state_reg == GRANT) & rdy[g_reg] & ~rempty & ~rrst;
  assign rinc = xfer;
  assign gnt  = gnt_reg;
  assign dout = rdata;
  assign busy = (state_reg == GRANT);

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    last_next  = last_reg;
    gnt_next   = gnt_reg;
`ifdef FIFO_ARB_BURST_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          g_next     = pick;
          gnt_next   = pick_onehot;
`ifdef FIFO_ARB_BURST_EN
          cnt_next   = '0;
`endif
        end
      end
      GRANT: begin
`ifdef FIFO_ARB_BURST_EN
        if (xfer) cnt_next = cnt_reg + 1'b1;
`endif
        if ((xfer && burst_done) || !req[g_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
          last_next  = g_reg;
`ifdef FIFO_ARB_BURST_EN
          cnt_next   = '0;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      gnt_reg   <= '0;
      last_reg  <= IW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
`ifdef FIFO_ARB_BURST_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a behavioural FIFO and a pop scoreboard.
// Expectations follow FIFO_ARB_BURST_EN the same way the design does.
module tb_fifo_rd_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic [NR-1:0] req, rdy, gnt, rvalid;
  logic [DW-1:0] dout;
  logic          busy;

  fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .req(req), .rdy(rdy), .gnt(gnt), .rvalid(rvalid), .dout(dout), .busy(busy)
  );

  always #5 rclk = ~rclk;

  // Behavioural FIFO: initial block owns the write side, the clocked block owns reads.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    rd_ptr = 8'd0;
  logic [7:0]    wr_ptr = 8'd0;
  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr];
  always @(posedge rclk) if (rinc === 1'b1) rd_ptr <= rd_ptr + 8'd1;

  // Every observed pop is logged; the initial block matches it against expectations.
  logic [NR-1:0] obs_gnt  [0:255];
  logic [DW-1:0] obs_data [0:255];
  int            obs_n = 0;
  always @(negedge rclk) begin
    if (rinc === 1'b1) begin
      obs_gnt[obs_n]  <= gnt;
      obs_data[obs_n] <= dout;
      obs_n           <= obs_n + 1;
    end
  end

  typedef struct { logic [NR-1:0] g; logic [DW-1:0] d; } exp_t;
  exp_t exp_q[$];
  int   obs_rd = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

`ifdef FIFO_ARB_BURST_EN
  localparam int BL       = MB;
  localparam int W5_FIRST = 3;
  localparam int W5_POPS  = 5;
  logic [0:15] pat_b4 = 16'b0111111110111111;
  logic [0:7]  pat_r5 = 8'b01110110;
  logic [3:0]  fin6   = 4'b0010;
`else
  localparam int BL       = 1;
  localparam int W5_FIRST = 1;
  localparam int W5_POPS  = 3;
  logic [0:15] pat_b4 = 16'b0110101010101011;
  logic [0:7]  pat_r5 = 8'b01010100;
  logic [3:0]  fin6   = 4'b0001;
`endif
  logic [0:15] pat_r4 = 16'b0010101010101000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input logic do_exp, input logic [NR-1:0] g);
    exp_t e;
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
    if (do_exp) begin
      e.g = g;
      e.d = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    req  = '0;
    rdy  = '0;
    tick();
    tick();
    rrst   = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_n) begin
        chk({tag, "_gnt"}, 32'(obs_gnt[obs_rd]), 32'(e.g));
        chk({tag, "_data"}, 32'(obs_data[obs_rd]), 32'(e.d));
        obs_rd++;
      end else begin
        chk({tag, "_missing_pop"}, 32'(obs_n), 32'(obs_rd + 1));
      end
    end
    chk({tag, "_pop_count"}, 32'(obs_n), 32'(obs_rd));
  endtask

  // Each grant: one idle cycle, then up to BL back-to-back pops.
  task automatic run_pattern(input string tag, input int words, input int rot, input logic [NR-1:0] fin);
    int rem = words;
    int k   = 0;
    int n;
    while (rem > 0) begin
      @(negedge rclk);
      chk({tag, "_bubble"}, {30'd0, rinc, busy}, 32'd0);
      tick();
      n = (rem < BL) ? rem : BL;
      for (int j = 0; j < n; j++) begin
        @(negedge rclk);
        chk({tag, "_rinc"}, 32'(rinc), 32'd1);
        chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << (k % rot)));
        chk({tag, "_rvalid"}, 32'(rvalid), 32'(4'b0001 << (k % rot)));
        tick();
      end
      rem -= n;
      k++;
    end
    repeat (3) tick();
    @(negedge rclk);
    chk({tag, "_hold_gnt"}, 32'(gnt), 32'(fin));
    chk({tag, "_hold_rinc"}, 32'(rinc), 32'd0);
    chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
    chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd0);
    tick();
  endtask

  initial begin
    rrst = 1'b1;
    req  = '0;
    rdy  = '0;

    // Reset then idle
    do_reset();
    @(negedge rclk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    tick();

    // Reset asserted while granted with rdy=1 and data available
    for (int i = 0; i < 8; i++) push_word(DW'($urandom), 1'b0, '0);
    req = 4'b0001;
    tick();
    @(negedge rclk);
    chk("midrst_pre_gnt", 32'(gnt), 32'b0001);
    chk("midrst_pre_rinc", 32'(rinc), 32'd0);
    tick();
    rrst = 1'b1;
    rdy  = 4'b0001;
    @(negedge rclk);
    chk("midrst_rinc", 32'(rinc), 32'd0);
    tick();
    rrst = 1'b0;
    req  = '0;
    rdy  = '0;
    @(negedge rclk);
    chk("midrst_gnt_after", 32'(gnt), 32'd0);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    tick();
    drain("midrst");

    // Single consumer, 10 words
    do_reset();
    for (int i = 0; i < 10; i++) push_word(DW'(8'h10 + i), 1'b1, 4'b0001);
    req = 4'b0001;
    rdy = 4'b0001;
    run_pattern("single", 10, 1, 4'b0001);
    drain("single");

    // Round-robin over four consumers, 32 words
    do_reset();
    for (int i = 0; i < 32; i++) push_word(DW'($urandom), 1'b1, 4'b0001 << ((i / BL) % 4));
    req = 4'b1111;
    rdy = 4'b1111;
    run_pattern("rr4", 32, 4, 4'b0001);
    drain("rr4");

    // Back-pressure: rdy high on even cycles only
    do_reset();
    for (int i = 0; i < 6; i++) push_word(DW'($urandom), 1'b1, 4'b0001);
    req = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      rdy = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      @(negedge rclk);
      chk($sformatf("bp_rinc_c%0d", c), 32'(rinc), 32'(pat_r4[c]));
      chk($sformatf("bp_busy_c%0d", c), 32'(busy), 32'(pat_b4[c]));
      tick();
    end
    drain("bp");

    // Withdrawal: req[2] drops on the third pop, then index 3 is served
    do_reset();
    for (int i = 0; i < W5_POPS; i++) push_word(DW'($urandom), 1'b1, (i < W5_FIRST) ? 4'b0100 : 4'b1000);
    for (int i = 0; i < 3; i++) push_word(DW'($urandom), 1'b0, '0);
    rdy = 4'b1111;
    req = 4'b1100;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) req = 4'b1000;
      if (c == 6) req = 4'b0000;
      @(negedge rclk);
      chk($sformatf("wd_rinc_c%0d", c), 32'(rinc), 32'(pat_r5[c]));
      if (c == 5) chk("wd_gnt_c5", 32'(gnt), 32'b1000);
      tick();
    end
    drain("wd");

    // Two consumers alternating
    do_reset();
    for (int i = 0; i < 6; i++) push_word(DW'($urandom), 1'b1, 4'b0001 << ((i / BL) % 2));
    req = 4'b0011;
    rdy = 4'b0011;
    run_pattern("rr2", 6, 2, fin6);
    drain("rr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
